pipe_stage_elastic: RTL



---
 rtl/pipe_pkg.sv | 29 ++
 rtl/sat_counter.sv | 36 +++
 rtl/pipe_stage_elastic.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the elastic inter-stage pipeline register family.
//   - state_t      : occupancy of a two-entry elastic stage
//   - stage widths : standard control/data widths per pipeline boundary
//   - has_room     : whether a given occupancy can still accept an entry
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Occupancy of the stage: nothing held, main register held, main+skid held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // EX/MEM boundary: M+WB control bits; ALU result 32 + store data 32 + rw 5.
  localparam int EX_MEM_CTRL_W = 4;
  localparam int EX_MEM_DATA_W = 69;

  // Default width of the performance counters attached to a stage.
  localparam int DEFAULT_CNT_W = 16;

  // The stage can accept a new entry unless both registers are occupied.
  function automatic logic has_room(input state_t s);
    return (s != TWO);
  endfunction

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter for performance statistics. Counts cycles with inc=1
//   and sticks at all-ones. Only a reset returns it to zero.
//
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   synchronous, active-high; clears the count
//     inc    in   add one this cycle (ignored once saturated)
//     count  out  W-bit current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule : sat_counter

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//   Generic inter-stage pipeline register with valid/ready handshake. A
//   2-entry skid buffer (main + skid) lets the upstream ready come straight
//   from a flop while still sustaining one transfer per cycle. The control
//   field is forced to zero on bubbles; the data field is not gated.
//   A synchronous flush squashes everything held, and a saturating counter
//   records cycles where the output is valid but not accepted.
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous, active-high; drops all entries
//     flush      in   synchronous squash of all held entries
//     in_valid   in   upstream has an entry
//     in_ready   out  stage can accept (registered)
//     in_ctrl    in   CTRL_W control bits
//     in_data    in   DATA_W payload
//     out_valid  out  output entry present
//     out_ready  in   downstream accepts
//     out_ctrl   out  CTRL_W control bits, zero when out_valid=0
//     out_data   out  DATA_W payload from the main register
//     stall_cnt  out  CNT_W saturating count of out_valid & !out_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EX_MEM_CTRL_W,
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Control state
  state_t r_state;
  state_t w_state_nxt;
  logic   r_in_ready;

  // Held entries: main always holds the oldest entry, skid the younger one.
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  // Handshake and register-load decodes
  logic w_out_valid;
  logic w_push;
  logic w_pop;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;
  logic w_stall;

  assign w_out_valid = (r_state != EMPTY);
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;
  assign w_stall     = w_out_valid & ~out_ready;

  // Next state and register-load selection. Flush overrides any push or pop;
  // a pop in the flush cycle still completes downstream because out_valid and
  // out_ready were both high, the stage simply ends up empty afterwards.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt  = ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_push) begin
            // Main is stalled: park the new entry behind it.
            w_state_nxt = TWO;
            w_ld_skid   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen; skid moves up.
          if (w_pop) begin
            w_state_nxt    = ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // State register and registered upstream ready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= has_room(w_state_nxt);
    end
  end

  // Entry registers. Flush leaves their contents alone; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_ld_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_ld_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  // Stall statistics
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  // Bubbles carry no control: a squashed or empty slot must not look like a
  // live memory/writeback operation to the next stage.
  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
  assign out_data  = r_main_data;

endmodule : pipe_stage_elastic
